// File: rtl/mul_seq_if.sv
// Operand/product handshake bundle for the sequential multiplier.
// The master side supplies operands and accepts products; the slave is the multiplier.
interface mul_seq_if #(
  parameter int W = 8
);
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] p;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output a, b, sgn, in_valid, out_ready,
    input  in_ready, p, out_valid
  );

  modport slave (
    input  a, b, sgn, in_valid, out_ready,
    output in_ready, p, out_valid
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier, unsigned or two's-complement signed.
// Signed operands are reduced to magnitudes at accept, multiplied unsigned,
// and the sign is applied once at the end. One operation in flight at a time.
module mul_seq #(
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  mul_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, OUT} state_t;

  localparam logic [W-1:0] CNT_INIT = W[W-1:0];

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   cnt_q;
  logic [2*W:0]   acc_q;
  logic [W-1:0]   mcand_q;
  logic           neg_q;
  logic [2*W-1:0] p_q;
  logic           out_valid_q;
  logic [W:0]     upper_sum;
  logic           accept;
  logic           step;

  // |v| as an unsigned W-bit value; the most negative input maps to 2^(W-1).
  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v,
                                             input logic is_signed);
    logic signed [W-1:0] neg_v;
    neg_v = -v;
    if (is_signed && v < 0) return $unsigned(neg_v);
    return $unsigned(v);
  endfunction

  // Two's-complement negate the full-width product when the result is negative.
  function automatic logic [2*W-1:0] apply_sign(input logic [2*W-1:0] mag,
                                                input logic neg);
    logic signed [2*W-1:0] neg_mag;
    neg_mag = -$signed(mag);
    if (neg) return $unsigned(neg_mag);
    return mag;
  endfunction

  assign accept        = bus.in_valid && (state_q == IDLE) && !clr;
  assign step          = (state_q == CALC) && (cnt_q != '0);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clr overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = SIGN;
      SIGN:    state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // Conditional add of the multiplicand into the upper half of the accumulator.
  always_comb begin
    upper_sum = acc_q[2*W:W];
    if (acc_q[0]) upper_sum = acc_q[2*W:W] + {1'b0, mcand_q};
  end

  // Step counter: loaded with W at accept, CALC exits once it has drained to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (accept) cnt_q <= CNT_INIT;
    else if (step)   cnt_q <= cnt_q - W'(1);
  end

  // Operand capture and add-shift datapath; multiplier bits drain out of the low end.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q   <= {{(W+1){1'b0}}, magnitude(bus.b, bus.sgn)};
      mcand_q <= magnitude(bus.a, bus.sgn);
      neg_q   <= bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
    end else if (step) begin
      acc_q   <= {1'b0, upper_sum, acc_q[W-1:1]};
    end
  end

  // Result register: signed product captured leaving SIGN and held until transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
    end else if (state_q == SIGN) begin
      out_valid_q <= 1'b1;
      p_q         <= apply_sign(acc_q[2*W-1:0], neg_q);
    end else if (state_q == OUT && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomized checks of mul_seq at W=8.
module tb_mul_seq;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  mul_seq_if #(.W(W)) bus ();

  mul_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("miscompare at %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    longint r;
    if (s) r = longint'($signed(a)) * longint'($signed(b));
    else   r = longint'(a) * longint'(b);
    return r[15:0];
  endfunction

  // One complete operation: accept, scramble inputs, measure latency, hold, transfer.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk($sformatf("%s ready", tag), bus.in_ready, 1);
    bus.a = a; bus.b = b; bus.sgn = s; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = b ^ 8'h5A; bus.sgn = ~s;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("%s latency", tag), lat, W + 2);
    chk($sformatf("%s product", tag), bus.p, exp);
    chk($sformatf("%s busy", tag), bus.in_ready, 0);
    repeat (hold) tick();
    if (hold > 0) begin
      chk($sformatf("%s held p", tag), bus.p, exp);
      chk($sformatf("%s held valid", tag), bus.out_valid, 1);
    end
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk($sformatf("%s valid drop", tag), bus.out_valid, 0);
    chk($sformatf("%s ready back", tag), bus.in_ready, 1);
  endtask

  // Abort an operation in its 4th CALC cycle via reset or clr, then prove recovery.
  task automatic abort_op(input string tag, input bit use_rst);
    int seen;
    bus.a = 8'd7; bus.b = 8'd9; bus.sgn = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    if (use_rst) begin
      rst_n = 1'b0;
      #1;
      chk($sformatf("%s rst ready", tag), bus.in_ready, 1);
      chk($sformatf("%s rst valid", tag), bus.out_valid, 0);
      chk($sformatf("%s rst p", tag), bus.p, 0);
      tick();
      rst_n = 1'b1;
    end else begin
      clr = 1'b1;
      tick();
      clr = 1'b0;
    end
    chk($sformatf("%s idle", tag), bus.in_ready, 1);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk($sformatf("%s no valid", tag), seen, 0);
    do_op($sformatf("%s 3x5", tag), 8'd3, 8'd5, 1'b0, 16'd15, 0);
  endtask

  initial begin
    bus.a = '0; bus.b = '0; bus.sgn = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #2;
    chk("reset ready", bus.in_ready, 1);
    chk("reset valid", bus.out_valid, 0);
    chk("reset p", bus.p, 0);
    tick();
    tick();
    rst_n = 1'b1;

    do_op("u 255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    do_op("s 80x80",   8'h80, 8'h80, 1'b1, 16'h4000, 0);
    do_op("s 80x7F",   8'h80, 8'h7F, 1'b1, 16'hC080, 0);
    do_op("u 0x5A",    8'h00, 8'h5A, 1'b0, 16'h0000, 0);
    do_op("s 0xA5",    8'h00, 8'hA5, 1'b1, 16'h0000, 0);
    do_op("s FFx01",   8'hFF, 8'h01, 1'b1, 16'hFFFF, 0);
    do_op("u FFx01",   8'hFF, 8'h01, 1'b0, 16'h00FF, 0);
    do_op("s FDx05",   8'hFD, 8'h05, 1'b1, 16'hFFF1, 0);
    do_op("s 7Fx7F",   8'h7F, 8'h7F, 1'b1, 16'h3F01, 0);
    do_op("u 80x7F",   8'h80, 8'h7F, 1'b0, 16'h3F80, 0);
    do_op("s hold",    8'h05, 8'hF9, 1'b1, 16'hFFDD, 20);

    abort_op("clr", 1'b0);
    abort_op("rst", 1'b1);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      do_op($sformatf("rnd%0d", i), ra, rb, rs, ref_mul(ra, rb, rs),
            int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
